// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit - registered ALU with Start/Done handshake; SLL/SRL/LUI iterate
// one bit per cycle. Optional macro OVERFLOW_DETECT_EN adds Overflow. Rev 1.0
// ============================================================================
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int LUI_SHIFT  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [3:0]            ALUOperation,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [4:0]            shamt,
   output logic                  Busy,
   output logic                  Done,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  BranchTaken,
   output logic                  IllegalOp
`ifdef OVERFLOW_DETECT_EN
   ,
   output logic                  Overflow
`endif
);

   localparam logic [3:0] C_OP_ADD = 4'b0000;
   localparam logic [3:0] C_OP_AND = 4'b0001;
   localparam logic [3:0] C_OP_NOR = 4'b0011;
   localparam logic [3:0] C_OP_OR  = 4'b0100;
   localparam logic [3:0] C_OP_SLL = 4'b0101;
   localparam logic [3:0] C_OP_SRL = 4'b0110;
   localparam logic [3:0] C_OP_SUB = 4'b0111;
   localparam logic [3:0] C_OP_BEQ = 4'b1000;
   localparam logic [3:0] C_OP_BNE = 4'b1001;
   localparam logic [3:0] C_OP_LUI = 4'b1010;
   localparam logic [3:0] C_OP_LW  = 4'b1011;
   localparam logic [3:0] C_OP_SW  = 4'b1100;
   localparam int C_MSB   = DATA_WIDTH - 1;
   localparam int C_CNT_W = ($clog2(DATA_WIDTH + 1) > 5) ? $clog2(DATA_WIDTH + 1) : 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [3:0]            op_q, op_d;
   logic [C_CNT_W-1:0]    cnt_q, cnt_d;
   logic                  done_q, done_d, zero_q, zero_d;
   logic                  branch_q, branch_d, illegal_q, illegal_d;
   logic [DATA_WIDTH-1:0] w_sum, w_diff, w_exec_res;
   logic                  w_exec_brn, w_exec_ill;

   assign w_sum  = a_q + b_q;
   assign w_diff = a_q - b_q;

   always_comb begin
      w_exec_res = '0;
      w_exec_brn = 1'b0;
      w_exec_ill = 1'b0;
      case (op_q)
         C_OP_ADD, C_OP_LW, C_OP_SW: w_exec_res = w_sum;
         C_OP_AND:                   w_exec_res = a_q & b_q;
         C_OP_NOR:                   w_exec_res = ~(a_q | b_q);
         C_OP_OR:                    w_exec_res = a_q | b_q;
         C_OP_SUB:                   w_exec_res = w_diff;
         C_OP_BEQ: begin
            w_exec_res = w_diff;
            w_exec_brn = (a_q == b_q);
         end
         C_OP_BNE: begin
            w_exec_res = w_diff;
            w_exec_brn = (a_q != b_q);
         end
         // Shift codes never reach EXEC; everything else left is an unknown code.
         default:                    w_exec_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      result_d  = result_q;
      zero_d    = zero_q;
      branch_d  = branch_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               a_d  = A;
               b_d  = B;
               op_d = ALUOperation;
               if (ALUOperation == C_OP_SLL || ALUOperation == C_OP_SRL) begin
                  cnt_d   = C_CNT_W'(shamt);
                  state_d = S_SHIFT;
               end else if (ALUOperation == C_OP_LUI) begin
                  cnt_d   = C_CNT_W'(LUI_SHIFT);
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            result_d  = w_exec_res;
            zero_d    = (w_exec_res == '0);
            branch_d  = w_exec_brn;
            illegal_d = w_exec_ill;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               b_d   = (op_q == C_OP_SRL) ? (b_q >> 1) : (b_q << 1);
               cnt_d = cnt_q - 1'b1;
            end else begin
               result_d  = b_q;
               zero_d    = (b_q == '0);
               branch_d  = 1'b0;
               illegal_d = 1'b0;
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         branch_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         branch_q  <= branch_d;
         illegal_q <= illegal_d;
      end
   end

   assign Busy        = (state_q != S_IDLE);
   assign Done        = done_q;
   assign ALUResult   = result_q;
   assign Zero        = zero_q;
   assign BranchTaken = branch_q;
   assign IllegalOp   = illegal_q;

`ifdef OVERFLOW_DETECT_EN
   logic ovf_q, ovf_d;
   logic w_add_ovf, w_sub_ovf;

   // Signed overflow: operands agree (add) / differ (sub) in sign and result sign flips.
   assign w_add_ovf = (a_q[C_MSB] == b_q[C_MSB]) && (w_sum[C_MSB] != a_q[C_MSB]);
   assign w_sub_ovf = (a_q[C_MSB] != b_q[C_MSB]) && (w_diff[C_MSB] != a_q[C_MSB]);

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == S_EXEC) begin
         ovf_d = (op_q == C_OP_ADD) ? w_add_ovf :
                 (op_q == C_OP_SUB) ? w_sub_ovf : 1'b0;
      end else if (state_q == S_SHIFT && cnt_q == '0) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign Overflow = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_unit - randomized self-checking bench for alu_exec_unit against a
// behavioural reference model. Rev 1.0
// ============================================================================
module tb_alu_exec_unit;

   localparam longint C_SMAX = 64'sh0000_0000_7FFF_FFFF;
   localparam longint C_SMIN = -64'sh0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  ALUOperation;
   logic [31:0] A, B;
   logic [4:0]  shamt;
   logic        Busy, Done, Zero, BranchTaken, IllegalOp;
   logic [31:0] ALUResult;
`ifdef OVERFLOW_DETECT_EN
   logic        Overflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_res;
   logic        exp_zero, exp_brn, exp_ill, exp_ovf;

   alu_exec_unit #(.DATA_WIDTH(32), .LUI_SHIFT(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .Start        (Start),
      .ALUOperation (ALUOperation),
      .A            (A),
      .B            (B),
      .shamt        (shamt),
      .Busy         (Busy),
      .Done         (Done),
      .ALUResult    (ALUResult),
      .Zero         (Zero),
      .BranchTaken  (BranchTaken),
      .IllegalOp    (IllegalOp)
`ifdef OVERFLOW_DETECT_EN
      ,
      .Overflow     (Overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: result, branch, illegal, overflow and Start-to-Done latency.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] res, output logic brn,
                        output logic ill, output logic ovf, output int lat);
      longint s;
      res = 32'h0; brn = 1'b0; ill = 1'b0; ovf = 1'b0; lat = 1;
      case (op)
         4'd0: begin
            res = a + b;
            s   = longint'($signed(a)) + longint'($signed(b));
            ovf = (s > C_SMAX) || (s < C_SMIN);
         end
         4'd1: res = a & b;
         4'd3: res = ~(a | b);
         4'd4: res = a | b;
         4'd5: begin res = b << sh; lat = int'(sh) + 1; end
         4'd6: begin res = b >> sh; lat = int'(sh) + 1; end
         4'd7: begin
            res = a - b;
            s   = longint'($signed(a)) - longint'($signed(b));
            ovf = (s > C_SMAX) || (s < C_SMIN);
         end
         4'd8: begin res = a - b; brn = (a == b); end
         4'd9: begin res = a - b; brn = (a != b); end
         4'd10: begin res = b << 16; lat = 17; end
         4'd11, 4'd12: res = a + b;
         default: ill = 1'b1;
      endcase
   endtask

   task automatic check_held();
      check_eq("hold_res", ALUResult, exp_res);
      check_eq("hold_zero", Zero, exp_zero);
      check_eq("hold_brn", BranchTaken, exp_brn);
      check_eq("hold_ill", IllegalOp, exp_ill);
`ifdef OVERFLOW_DETECT_EN
      check_eq("hold_ovf", Overflow, exp_ovf);
`endif
   endtask

   // Called just after a negedge; returns at the negedge where Done is seen.
   // poke_k < 0 picks a random busy cycle for an extra (ignored) Start; 0 disables it.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int poke_k);
      logic [31:0] m_res;
      logic        m_brn, m_ill, m_ovf;
      int          m_lat, k, busy_n, pk;
      model(op, a, b, sh, m_res, m_brn, m_ill, m_ovf, m_lat);
      pk = (poke_k < 0) ? 1 + int'($urandom_range(m_lat - 1, 0)) : poke_k;
      ALUOperation = op; A = a; B = b; shamt = sh; Start = 1'b1;
      k = 0; busy_n = 0;
      do begin
         @(negedge clk);
         k++;
         Start        = (k == pk);
         ALUOperation = 4'($urandom);
         A            = $urandom;
         B            = $urandom;
         shamt        = 5'($urandom);
         if (Busy) busy_n++;
      end while (!Done && k <= m_lat + 4);
      Start = 1'b0;
      check_eq("done_seen", Done, 1'b1);
      check_eq("latency", k - 1, m_lat);
      check_eq("busy_cycles", busy_n, m_lat);
      check_eq("busy_at_done", Busy, 1'b0);
      check_eq("result", ALUResult, m_res);
      check_eq("zero", Zero, (m_res == 32'h0));
      check_eq("branch", BranchTaken, m_brn);
      check_eq("illegal", IllegalOp, m_ill);
`ifdef OVERFLOW_DETECT_EN
      check_eq("overflow", Overflow, m_ovf);
`endif
      exp_res = m_res; exp_zero = (m_res == 32'h0); exp_brn = m_brn;
      exp_ill = m_ill; exp_ovf = m_ovf;
   endtask

   task automatic idle(input int n);
      Start = 1'b0;
      repeat (n) begin
         @(negedge clk);
         A = $urandom;
         B = $urandom;
         check_eq("idle_done", Done, 1'b0);
         check_eq("idle_busy", Busy, 1'b0);
         check_held();
      end
   endtask

   task automatic clear_exp();
      exp_res = 32'h0; exp_zero = 1'b0; exp_brn = 1'b0; exp_ill = 1'b0; exp_ovf = 1'b0;
   endtask

   initial begin
      logic [3:0]  t_op;
      logic [31:0] t_a, t_b;
      reset = 1'b0; Start = 1'b0; ALUOperation = 4'h0; A = 32'h0; B = 32'h0; shamt = 5'h0;
      clear_exp();
      #1;
      check_eq("rst_busy", Busy, 1'b0);
      check_eq("rst_done", Done, 1'b0);
      check_held();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(2);

      run_op(4'd0, 32'h7, 32'h5, 5'd0, 0);               // ADD 7+5
      idle(1);
      run_op(4'd5, 32'h0, 32'h1, 5'd4, 0);               // SLL by 4
      run_op(4'd5, 32'h0, 32'h1, 5'd0, 0);               // SLL by 0, accepted in Done cycle
      run_op(4'd10, 32'h0, 32'h0000_1234, 5'd0, 3);      // LUI with ignored Start
      run_op(4'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd0, 1); // BEQ taken
      run_op(4'd9, 32'h1, 32'h2, 5'd0, 0);               // BNE taken
      run_op(4'd15, 32'h1, 32'h2, 5'd0, 0);              // illegal
      run_op(4'd4, 32'h0F0, 32'h00F, 5'd0, 0);           // OR clears IllegalOp
      run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);       // signed overflow
      run_op(4'd7, 32'h8000_0000, 32'h1, 5'd0, 0);
      run_op(4'd6, 32'h0, 32'h8000_0000, 5'd31, -1);     // SRL max distance
      idle(2);

      // Reset in the middle of a long SRL: no Done, outputs cleared at once.
      ALUOperation = 4'd6; B = 32'hFFFF_0000; shamt = 5'd20; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("pre_rst_busy", Busy, 1'b1);
      reset = 1'b0;
      clear_exp();
      #1;
      check_eq("mid_rst_busy", Busy, 1'b0);
      check_eq("mid_rst_done", Done, 1'b0);
      check_held();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(25);
      run_op(4'd0, 32'h1, 32'h1, 5'd0, 0);
      idle(1);

      for (int i = 0; i < 150; i++) begin
         t_op = 4'($urandom);
         t_a  = ($urandom_range(3, 0) == 0) ? 32'h7FFF_FFFF : $urandom;
         t_b  = ($urandom_range(3, 0) == 0) ? t_a : $urandom;
         run_op(t_op, t_a, t_b, 5'($urandom), ($urandom_range(1, 0) == 1) ? -1 : 0);
         if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(3, 1)));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
